// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed scanner for the eight seven-segment digits of the
// Nexys 4 DDR. Each digit owns a slot of TICK_DIV cycles. The first BLANK
// cycles of every slot keep all anodes off so the previous digit's cathode
// pattern cannot ghost onto the next one. Eight slots make one frame.
//
// Display data is double-buffered:
//   - load writes value/dig_en/dp_en into the pending registers.
//   - The active registers take the pending contents only at a frame
//     boundary, which is the last cycle of slot 7. A frame therefore never
//     mixes old and new data.
//
// Handshake: load is a plain single-cycle strobe with no ready. It is
// always accepted unless rst is high. A later load before the boundary
// overwrites an earlier one. A load in the boundary cycle itself stays
// pending for the next frame.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   value      32-bit hex value; nibble k is shown on digit k (AN[0] = right)
//   dig_en     per-digit enable
//   dp_en      per-digit decimal-point enable
//   load       strobe that captures value/dig_en/dp_en into pending
//   AN         anodes, active-low
//   Ca         cathodes a..g on bits 0..6, active-low
//   DP         decimal point, active-low
//   pend       pending data not yet transferred to the display
//   frame_done one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int TICK_DIV = 12500,
  parameter int BLANK    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [7:0]  dig_en,
  input  logic [7:0]  dp_en,
  input  logic        load,
  output logic [7:0]  AN,
  output logic [6:0]  Ca,
  output logic        DP,
  output logic        pend,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  logic [31:0] act_value;
  logic [7:0]  act_dig;
  logic [7:0]  act_dp;
  logic [31:0] pnd_value;
  logic [7:0]  pnd_dig;
  logic [7:0]  pnd_dp;

  logic        boundary;
  logic        lit;
  logic [3:0]  nib;
  logic [7:0]  an_next;
  logic [6:0]  ca_next;
  logic        dp_next;

  // Active-low hex decoder; bit 0 is segment a.
  function automatic logic [6:0] hex7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    boundary = (cnt == CNT_MAX) && (idx == 3'd7);
    lit      = (cnt >= BLANK_C) && act_dig[idx];
    nib      = act_value[{idx, 2'b00} +: 4];
    an_next  = 8'hFF;
    ca_next  = 7'h7F;
    dp_next  = 1'b1;
    if (lit) begin
      // Only one anode is ever pulled low: the one for the current slot.
      an_next = ~(8'b0000_0001 << idx);
      ca_next = hex7seg(nib);
      dp_next = ~act_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 3'd0;
      act_value  <= 32'h0;
      act_dig    <= 8'h0;
      act_dp     <= 8'h0;
      pnd_value  <= 32'h0;
      pnd_dig    <= 8'h0;
      pnd_dp     <= 8'h0;
      pend       <= 1'b0;
      frame_done <= 1'b0;
      AN         <= 8'hFF;
      Ca         <= 7'h7F;
      DP         <= 1'b1;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      frame_done <= boundary;

      // The transfer uses the pending contents held before this edge. A
      // load in the boundary cycle therefore waits for the next frame.
      if (boundary && pend) begin
        act_value <= pnd_value;
        act_dig   <= pnd_dig;
        act_dp    <= pnd_dp;
      end

      if (load) begin
        pnd_value <= value;
        pnd_dig   <= dig_en;
        pnd_dp    <= dp_en;
      end

      pend <= load | (pend & ~boundary);

      AN <= an_next;
      Ca <= ca_next;
      DP <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// Bench for seg_scan_mux with TICK_DIV=4 and BLANK=1, which gives a 32-cycle
// frame.
//
// The reference model works from the cycle number n counted since reset
// release. From n it derives the slot as (n / TD) % 8, the slot cycle as
// n % TD, and the boundary as n % 32 == 31. It keeps the active and pending
// display data as plain variables and predicts the pins one cycle later.
//
// Inputs are driven on the falling edge. Outputs are sampled on the next
// falling edge, after the rising edge that registered them.
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;
  localparam int TD = 4;
  localparam int BL = 1;
  localparam int FL = 8 * TD;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  dig_en;
  logic [7:0]  dp_en;
  logic        load;
  logic [7:0]  AN;
  logic [6:0]  Ca;
  logic        DP;
  logic        pend;
  logic        frame_done;

  seg_scan_mux #(.TICK_DIV(TD), .BLANK(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dig_en     (dig_en),
    .dp_en      (dp_en),
    .load       (load),
    .AN         (AN),
    .Ca         (Ca),
    .DP         (DP),
    .pend       (pend),
    .frame_done (frame_done)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int          vectors;
  int          miscompares;
  int          m_n;
  logic [31:0] m_act_val;
  logic [7:0]  m_act_dig;
  logic [7:0]  m_act_dp;
  logic [31:0] m_pnd_val;
  logic [7:0]  m_pnd_dig;
  logic [7:0]  m_pnd_dp;
  logic        m_pend;
  logic [6:0]  seg_tab [16];

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, m_n, got, exp);
    end
  endtask

  task automatic model_clear();
    m_n       = 0;
    m_act_val = 32'h0;
    m_act_dig = 8'h0;
    m_act_dp  = 8'h0;
    m_pnd_val = 32'h0;
    m_pnd_dig = 8'h0;
    m_pnd_dp  = 8'h0;
    m_pend    = 1'b0;
  endtask

  // Reset for n cycles. load is held high throughout with random data,
  // because a load during reset must be ignored.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst    = 1'b1;
      load   = 1'b1;
      value  = $urandom;
      dig_en = 8'($urandom);
      dp_en  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("rst_an", AN, 8'hFF);
      chk("rst_ca", Ca, 7'h7F);
      chk("rst_dp", DP, 1'b1);
      chk("rst_fd", frame_done, 1'b0);
      chk("rst_pend", pend, 1'b0);
    end
    rst  = 1'b0;
    load = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive the inputs, predict the registered pins, then
  // compare them after the edge.
  task automatic tick(input logic ld, input logic [31:0] v, input logic [7:0] de,
                      input logic [7:0] dpe);
    int         slot;
    int         c;
    logic       bnd;
    logic [7:0] e_an;
    logic [6:0] e_ca;
    logic       e_dp;
    logic [3:0] nib;
    load   = ld;
    value  = v;
    dig_en = de;
    dp_en  = dpe;
    slot = (m_n / TD) % 8;
    c    = m_n % TD;
    bnd  = ((m_n % FL) == FL - 1);
    e_an = 8'hFF;
    e_ca = 7'h7F;
    e_dp = 1'b1;
    if (c >= BL && m_act_dig[slot]) begin
      nib  = 4'((m_act_val >> (4 * slot)) & 32'hF);
      e_an = 8'hFF ^ (8'd1 << slot);
      e_ca = seg_tab[nib];
      e_dp = ~m_act_dp[slot];
    end
    if (bnd && m_pend) begin
      m_act_val = m_pnd_val;
      m_act_dig = m_pnd_dig;
      m_act_dp  = m_pnd_dp;
      m_pend    = 1'b0;
    end
    if (ld) begin
      m_pnd_val = v;
      m_pnd_dig = de;
      m_pnd_dp  = dpe;
      m_pend    = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("an", AN, e_an);
    chk("ca", Ca, e_ca);
    chk("dp", DP, e_dp);
    chk("frame_done", frame_done, bnd);
    chk("pend", pend, m_pend);
    chk("an_onehot", ($countones(~AN) <= 1), 1);
    m_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  // Advance until the next cycle to be driven has the given frame
  // position. This takes at most one frame of idle cycles.
  task automatic align(input int pos);
    for (int i = 0; i < FL && (m_n % FL) != pos; i++) tick(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    load   = 1'b0;
    value  = 32'h0;
    dig_en = 8'h0;
    dp_en  = 8'h0;
    model_clear();
    @(negedge clk);

    // Reset blank: two frames with no load.
    do_reset(3);
    idle(2 * FL);

    // Full scan.
    tick(1'b1, 32'h89ABCDEF, 8'hFF, 8'h01);
    align(0);
    idle(2 * FL);

    // Double buffering: the second load in the frame wins.
    align(4);
    tick(1'b1, 32'h00000000, 8'hFF, 8'h00);
    idle(5);
    tick(1'b1, 32'h11111111, 8'hFF, 8'h00);
    align(0);
    idle(FL);

    // Load on the boundary cycle (cnt=3, idx=7).
    align(FL - 1);
    tick(1'b1, 32'h76543210, 8'hFF, 8'hA5);
    idle(2 * FL + 2);

    // Digit masking: only digit 2 is lit.
    tick(1'b1, 32'h00000500, 8'b0000_0100, 8'h00);
    align(0);
    idle(2 * FL);

    // Reset mid-operation with an update pending (idx=4, cnt=2).
    align(10);
    tick(1'b1, 32'hDEADBEEF, 8'hFF, 8'hFF);
    align(18);
    do_reset(1);
    idle(2 * FL);

    // Randomized loads at random points in the frame.
    for (int r = 0; r < 24; r++) begin
      idle($urandom_range(0, 40));
      tick(1'b1, $urandom, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(0, 20));
        tick(1'b1, $urandom, 8'($urandom), 8'($urandom));
      end
    end
    idle(2 * FL + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scanner that drives all eight seven-segment displays of the Nexys 4 DDR with independent hex digits. It sits directly upstream of the board's anode/cathode pins, replacing static switch-driven anode selection. It takes a 32-bit value plus per-digit enable and decimal-point masks, and produces the active-low AN/Ca/DP pin vectors. Updates are double-buffered and take effect only on frame boundaries, so the display never tears.

## Interface
- TICK_DIV, 12500 — clock cycles per digit slot; 8 kHz slot rate and 1 kHz frame rate at 100 MHz; legal range ≥ 2.
- BLANK, 64 — cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 ≤ BLANK < TICK_DIV.
- clk  in  1  — 100 MHz system clock.
- rst  in  1  — synchronous reset, active-high.
- value  in  32  — hex nibbles; value[4k+3:4k] is shown on digit k (digit 0 = rightmost, AN[0]).
- dig_en  in  8  — bit k=1 lights digit k.
- dp_en  in  8  — bit k=1 lights the decimal point of digit k.
- load  in  1  — single-cycle strobe; captures value/dig_en/dp_en into pending registers.
- AN  out  8  — anodes, active-low.
- Ca  out  7  — cathodes, active-low; Ca[0]=a … Ca[6]=g.
- DP  out  1  — decimal point, active-low.
- pend  out  1  — pending update not yet applied.
- frame_done  out  1  — one-cycle pulse at each frame boundary.

## Operation
- Slot counter cnt (0..TICK_DIV-1) increments every cycle and wraps to 0. On wrap, digit index idx (3-bit) increments; 7 wraps to 0.
- Frame boundary: the cycle where cnt==TICK_DIV-1 and idx==7. In that cycle:
  - frame_done is asserted on the next edge, for one cycle.
  - If pend=1, the active registers are set to the pending registers and pend is cleared.
- load captures inputs into pending and sets pend. A second load before the boundary overwrites the first; the last one wins.
- load in the boundary cycle itself: the boundary transfers the old pending contents (if any). The new load stays pending (pend=1) until the next boundary.
- Output decode for current idx=k, using active registers:
  - cnt < BLANK: AN=8'hFF, Ca=7'h7F, DP=1.
  - Otherwise: AN = ~(8'b1 << k) if active dig_en[k], else 8'hFF.
  - Ca = hex7seg(nibble k) when lit, else 7'h7F.
  - DP = ~active dp_en[k] when lit, else 1.
- hex7seg, active-low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- At most one AN bit is low at any time.

## Timing
- Reset values:
  - AN=8'hFF, Ca=7'h7F, DP=1, frame_done=0, pend=0.
  - cnt=0, idx=0; active and pending registers all 0, so the display is blank until the first load is applied.
- All outputs are registered: pins in cycle t+1 reflect cnt/idx/active state in cycle t.
- Frame length is exactly 8·TICK_DIV cycles.
- The first frame_done pulse appears 8·TICK_DIV cycles after rst deasserts.
- Load-to-display latency is at most 8·TICK_DIV+1 cycles.
- The new data first appears on digit 0, at slot cycle BLANK+1 after the boundary.
- rst asserted mid-frame: outputs return to reset values on the next edge, and pending data is discarded.
- load with rst high is ignored.

## Test plan
- Reset blank (TICK_DIV=4, BLANK=1): hold rst 3 cycles, release, no load for 2 frames.
  - Required: AN=FF, Ca=7F, DP=1 throughout; frame_done pulses at cycles 32 and 64 after release; pend=0.
- Full scan: load value=32'h89ABCDEF, dig_en=FF, dp_en=01, then wait one boundary.
  - Required: on the next frame, digit 0 shows AN=FE, Ca=0E, DP=0; digit 7 shows AN=7F, Ca=00, DP=1.
  - Required: AN=FF on the first cycle of every slot.
  - Required: never two AN bits low at once.
- Double buffering: load 32'h00000000, then load 32'h11111111 mid-frame.
  - Required: pend=1 after the first load; the next frame shows only 1s (Ca=79); pend drops in the same cycle as the frame_done pulse.
- Load on boundary cycle: assert load exactly when cnt=3, idx=7.
  - Required: the frame immediately after still shows the old data; pend stays 1; the new data appears one frame later.
- Digit masking: dig_en=8'b00000100, value=32'h00000500.
  - Required: only slot 2 drives AN=FB with Ca=12; all other slots keep AN=FF.
- Reset mid-operation: assert rst during idx=4, cnt=2 with pend=1.
  - Required: outputs go to reset values on the next edge; after release, the display stays blank and pend=0.
